// File: rtl/laser_shot_sequencer_if.sv
// Register-file side of the laser shot sequencer: burst configuration,
// start/abort commands and the per-burst status the register file reads back.
interface laser_shot_sequencer_if #(
    parameter int CW = 27,
    parameter int SW = 16
);
    logic          start;
    logic          abort;
    logic [1:0]    cfg_mode;
    logic [SW-1:0] cfg_shots;
    logic [CW-1:0] cfg_charge_len;
    logic [CW-1:0] cfg_pulse_len;
    logic [CW-1:0] cfg_holdoff;

    logic          busy;
    logic          done;
    logic          aborted;
    logic          timeout;
    logic          cfg_err;
    logic [SW-1:0] shot_idx;
    logic [SW-1:0] cmp_hits;

    // The register file issues commands and configuration, reads status.
    modport master (
        output start, abort, cfg_mode, cfg_shots, cfg_charge_len, cfg_pulse_len, cfg_holdoff,
        input  busy, done, aborted, timeout, cfg_err, shot_idx, cmp_hits
    );

    // The sequencer consumes commands and configuration, produces status.
    modport slave (
        input  start, abort, cfg_mode, cfg_shots, cfg_charge_len, cfg_pulse_len, cfg_holdoff,
        output busy, done, aborted, timeout, cfg_err, shot_idx, cmp_hits
    );
endinterface

// File: rtl/laser_shot_sequencer.sv
// Laser shot sequencer: runs a burst of CHARGE -> FIRE -> HOLDOFF shots.
// FIRE ends on a fixed length, on a synchronized comparator rising edge, or
// on whichever comes first; comparator-only firing is capped at MAX_FIRE cycles.
module laser_shot_sequencer #(
    parameter int CW       = 27,
    parameter int SW       = 16,
    parameter int MAX_FIRE = 4095
) (
    input  logic                    avms_clk,
    input  logic                    avms_reset,
    laser_shot_sequencer_if.slave   regs,
    input  logic                    comparator,
    output logic                    laser_charge,
    output logic                    laser_en
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHARGE  = 2'd1,
        FIRE    = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam logic [1:0]    MODE_LEN     = 2'b00;
    localparam logic [1:0]    MODE_CMP     = 2'b01;
    localparam logic [1:0]    MODE_EITHER  = 2'b10;
    localparam logic [1:0]    MODE_RSVD    = 2'b11;
    localparam logic [CW-1:0] FIRE_CAP_LD  = CW'(MAX_FIRE - 1);
    localparam logic [SW-1:0] COUNT_MAX    = '1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    mode_q;
    logic [SW-1:0] shots_q;
    logic [CW-1:0] charge_ld;
    logic [CW-1:0] pulse_ld;
    logic [CW-1:0] holdoff_ld;

    logic cmp_s1;
    logic cmp_s2;
    logic cmp_d;
    logic cmp_edge;
    logic cnt_zero;
    logic fire_done;
    logic fire_hit;
    logic fire_to;

    // A zero length behaves as one cycle; the counter holds length-1 so
    // every state lasts exactly max(len,1) cycles.
    function automatic logic [CW-1:0] len_load(input logic [CW-1:0] len);
        return (len == '0) ? '0 : len - CW'(1);
    endfunction

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] val);
        return (val == COUNT_MAX) ? COUNT_MAX : val + SW'(1);
    endfunction

    assign cmp_edge = cmp_s2 & ~cmp_d;
    assign cnt_zero = (cnt == '0);

    // Two-flop synchronizer plus a delayed copy for rising-edge detection.
    always_ff @(posedge avms_clk or posedge avms_reset) begin
        if (avms_reset) begin
            cmp_s1 <= 1'b0;
            cmp_s2 <= 1'b0;
            cmp_d  <= 1'b0;
        end else begin
            cmp_s1 <= comparator;
            cmp_s2 <= cmp_s1;
            cmp_d  <= cmp_s2;
        end
    end

    // Decide how the current FIRE cycle ends; an edge takes priority over
    // expiry so an edge in the expiry cycle still counts as a hit.
    always_comb begin
        fire_done = 1'b0;
        fire_hit  = 1'b0;
        fire_to   = 1'b0;
        case (mode_q)
            MODE_CMP: begin
                if (cmp_edge) begin
                    fire_done = 1'b1;
                    fire_hit  = 1'b1;
                end else if (cnt_zero) begin
                    fire_done = 1'b1;
                    fire_to   = 1'b1;
                end
            end
            MODE_EITHER: begin
                fire_hit  = cmp_edge;
                fire_done = cmp_edge | cnt_zero;
            end
            default: begin
                fire_done = cnt_zero;
            end
        endcase
    end

    // Burst FSM; the laser pins and busy are registered alongside the state.
    always_ff @(posedge avms_clk or posedge avms_reset) begin
        if (avms_reset) begin
            state         <= IDLE;
            cnt           <= '0;
            mode_q        <= MODE_LEN;
            shots_q       <= '0;
            charge_ld     <= '0;
            pulse_ld      <= '0;
            holdoff_ld    <= '0;
            laser_charge  <= 1'b0;
            laser_en      <= 1'b0;
            regs.busy     <= 1'b0;
            regs.done     <= 1'b0;
            regs.aborted  <= 1'b0;
            regs.timeout  <= 1'b0;
            regs.cfg_err  <= 1'b0;
            regs.shot_idx <= '0;
            regs.cmp_hits <= '0;
        end else begin
            regs.done <= 1'b0;
            if (!cnt_zero) begin
                cnt <= cnt - CW'(1);
            end

            if (state != IDLE && regs.abort) begin
                state        <= IDLE;
                laser_charge <= 1'b0;
                laser_en     <= 1'b0;
                regs.busy    <= 1'b0;
                regs.done    <= 1'b1;
                regs.aborted <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (regs.start && !regs.abort) begin
                            if (regs.cfg_mode == MODE_RSVD) begin
                                regs.cfg_err <= 1'b1;
                            end else begin
                                mode_q        <= regs.cfg_mode;
                                shots_q       <= (regs.cfg_shots == '0) ? SW'(1) : regs.cfg_shots;
                                charge_ld     <= len_load(regs.cfg_charge_len);
                                pulse_ld      <= len_load(regs.cfg_pulse_len);
                                holdoff_ld    <= len_load(regs.cfg_holdoff);
                                cnt           <= len_load(regs.cfg_charge_len);
                                regs.shot_idx <= '0;
                                regs.cmp_hits <= '0;
                                regs.aborted  <= 1'b0;
                                regs.timeout  <= 1'b0;
                                regs.cfg_err  <= 1'b0;
                                state         <= CHARGE;
                                laser_charge  <= 1'b1;
                                regs.busy     <= 1'b1;
                            end
                        end
                    end
                    CHARGE: begin
                        if (cnt_zero) begin
                            state        <= FIRE;
                            laser_charge <= 1'b0;
                            laser_en     <= 1'b1;
                            cnt          <= (mode_q == MODE_CMP) ? FIRE_CAP_LD : pulse_ld;
                        end
                    end
                    FIRE: begin
                        if (fire_done) begin
                            state         <= HOLDOFF;
                            laser_en      <= 1'b0;
                            cnt           <= holdoff_ld;
                            regs.shot_idx <= sat_inc(regs.shot_idx);
                            if (fire_hit) begin
                                regs.cmp_hits <= sat_inc(regs.cmp_hits);
                            end
                            if (fire_to) begin
                                regs.timeout <= 1'b1;
                            end
                        end
                    end
                    HOLDOFF: begin
                        if (cnt_zero) begin
                            if (regs.shot_idx < shots_q) begin
                                state        <= CHARGE;
                                laser_charge <= 1'b1;
                                cnt          <= charge_ld;
                            end else begin
                                state     <= IDLE;
                                regs.busy <= 1'b0;
                                regs.done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        laser_charge <= 1'b0;
                        laser_en     <= 1'b0;
                        regs.busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_laser_shot_sequencer.sv
// Self-checking bench for laser_shot_sequencer: expected burst summaries are
// queued when a burst is started and compared when the DUT pulses done.
module tb_laser_shot_sequencer;

    localparam int CW       = 27;
    localparam int SW       = 16;
    localparam int MAX_FIRE = 4095;

    typedef struct {
        int charge;
        int en;
        int pulses;
        int period;
        int fall_to_done;
        int shot_idx;
        int cmp_hits;
        int aborted;
        int timeout;
    } exp_t;

    logic avms_clk   = 1'b0;
    logic avms_reset = 1'b1;
    logic comparator = 1'b0;
    logic laser_charge;
    logic laser_en;

    exp_t expQ[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    laser_shot_sequencer_if #(.CW(CW), .SW(SW)) regs ();

    laser_shot_sequencer #(.CW(CW), .SW(SW), .MAX_FIRE(MAX_FIRE)) dut (
        .avms_clk     (avms_clk),
        .avms_reset   (avms_reset),
        .regs         (regs),
        .comparator   (comparator),
        .laser_charge (laser_charge),
        .laser_en     (laser_en)
    );

    // Free-running 100 MHz clock.
    always #5 avms_clk = ~avms_clk;

    function automatic exp_t mkExp(input int charge, input int en, input int pulses, input int period,
                                   input int ftd, input int shot, input int hits, input int ab, input int to);
        exp_t e;
        e.charge = charge; e.en = en; e.pulses = pulses; e.period = period;
        e.fall_to_done = ftd; e.shot_idx = shot; e.cmp_hits = hits; e.aborted = ab; e.timeout = to;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one start (optionally with abort) at a negedge; queue the expected burst.
    task automatic applyStimulus(input logic [1:0] mode, input int shots, input int charge_len,
                                 input int pulse_len, input int holdoff, input bit with_abort,
                                 input bit expect_burst, input exp_t e);
        if (expect_burst) expQ.push_back(e);
        regs.cfg_mode       = mode;
        regs.cfg_shots      = SW'(shots);
        regs.cfg_charge_len = CW'(charge_len);
        regs.cfg_pulse_len  = CW'(pulse_len);
        regs.cfg_holdoff    = CW'(holdoff);
        regs.start          = 1'b1;
        regs.abort          = with_abort;
        @(negedge avms_clk);
        regs.start = 1'b0;
        regs.abort = 1'b0;
    endtask

    // Watch a burst until done, injecting comparator edges / abort / a
    // mid-burst start, then pop the scoreboard entry and compare.
    task automatic observeBurst(input string name, input int max_cyc, input int cmp_fire_cyc,
                                input int abort_shot, input int abort_fire_cyc, input bit poke_mid);
        int charge = 0, en = 0, pulses = 0, fire_cyc = 0, cyc = 0;
        int first_rise = -1, second_rise = -1, last_fall = -1, done_at = -1;
        int extra_done = 0, busy_after = 0, en_at_done = 0;
        int shot_obs = 0, hits_obs = 0, ab_obs = 0, to_obs = 0, err_obs = 0;
        bit prev_en = 1'b0, got_done = 1'b0;
        exp_t e;
        while (!got_done && cyc < max_cyc) begin
            if (laser_charge) charge++;
            if (laser_en) begin
                en++;
                if (!prev_en) begin
                    pulses++;
                    fire_cyc = 1;
                    if (first_rise < 0) first_rise = cyc;
                    else if (second_rise < 0) second_rise = cyc;
                end else begin
                    fire_cyc++;
                end
            end
            if (prev_en && !laser_en) last_fall = cyc;
            if (regs.done) begin
                got_done   = 1'b1;
                done_at    = cyc;
                en_at_done = int'(laser_en);
                shot_obs   = int'(regs.shot_idx);
                hits_obs   = int'(regs.cmp_hits);
                ab_obs     = int'(regs.aborted);
                to_obs     = int'(regs.timeout);
                err_obs    = int'(regs.cfg_err);
                break;
            end
            if (cmp_fire_cyc != 0 && laser_en && pulses == 1 && fire_cyc == cmp_fire_cyc) comparator = 1'b1;
            regs.abort = (abort_shot != 0 && laser_en && pulses == abort_shot && fire_cyc == abort_fire_cyc);
            if (poke_mid && cyc == 3) begin
                regs.start     = 1'b1;
                regs.cfg_shots = SW'(1);
                regs.cfg_mode  = 2'b01;
            end else begin
                regs.start = 1'b0;
            end
            prev_en = laser_en;
            @(negedge avms_clk);
            cyc++;
        end
        regs.abort = 1'b0;
        regs.start = 1'b0;
        comparator = 1'b0;
        checkOutput($sformatf("%s done_seen", name), int'(got_done), 1);
        if (expQ.size() == 0) begin
            checkOutput($sformatf("%s scoreboard_entry", name), 0, 1);
        end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("%s charge_cycles", name), charge, e.charge);
            checkOutput($sformatf("%s fire_cycles", name), en, e.en);
            checkOutput($sformatf("%s fire_pulses", name), pulses, e.pulses);
            checkOutput($sformatf("%s shot_period", name),
                        (second_rise >= 0) ? second_rise - first_rise : -1, e.period);
            checkOutput($sformatf("%s fall_to_done", name), done_at - last_fall, e.fall_to_done);
            checkOutput($sformatf("%s shot_idx", name), shot_obs, e.shot_idx);
            checkOutput($sformatf("%s cmp_hits", name), hits_obs, e.cmp_hits);
            checkOutput($sformatf("%s aborted", name), ab_obs, e.aborted);
            checkOutput($sformatf("%s timeout", name), to_obs, e.timeout);
            checkOutput($sformatf("%s cfg_err", name), err_obs, 0);
            checkOutput($sformatf("%s laser_en_at_done", name), en_at_done, 0);
        end
        repeat (3) begin
            @(negedge avms_clk);
            extra_done += int'(regs.done);
            busy_after += int'(regs.busy) + int'(laser_en) + int'(laser_charge);
        end
        checkOutput($sformatf("%s extra_done", name), extra_done, 0);
        checkOutput($sformatf("%s idle_after", name), busy_after, 0);
    endtask

    // Count any laser/busy/done activity over a few idle cycles.
    task automatic idleActivity(input int cycles, output int activity);
        activity = 0;
        repeat (cycles) begin
            @(negedge avms_clk);
            activity += int'(laser_en) + int'(laser_charge) + int'(regs.busy) + int'(regs.done);
        end
    endtask

    // Directed test sequence.
    initial begin
        exp_t none;
        int   act;
        none = mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        regs.start = 1'b0; regs.abort = 1'b0; regs.cfg_mode = 2'b00; regs.cfg_shots = '0;
        regs.cfg_charge_len = '0; regs.cfg_pulse_len = '0; regs.cfg_holdoff = '0;

        repeat (2) @(negedge avms_clk);
        checkOutput("reset laser_en", int'(laser_en), 0);
        checkOutput("reset laser_charge", int'(laser_charge), 0);
        checkOutput("reset busy_done", int'(regs.busy) + int'(regs.done), 0);
        checkOutput("reset flags", int'(regs.aborted) + int'(regs.timeout) + int'(regs.cfg_err), 0);
        checkOutput("reset counters", int'(regs.shot_idx) + int'(regs.cmp_hits), 0);
        avms_reset = 1'b0;
        @(negedge avms_clk);

        applyStimulus(2'b00, 1, 3, 5, 2, 1'b0, 1'b1, mkExp(3, 5, 1, -1, 2, 1, 0, 0, 0));
        observeBurst("fixed_single", 100, 0, 0, 0, 1'b0);

        applyStimulus(2'b10, 1, 2, 100, 3, 1'b0, 1'b1, mkExp(2, 12, 1, -1, 3, 1, 1, 0, 0));
        observeBurst("either_cmp10", 300, 10, 0, 0, 1'b0);

        applyStimulus(2'b01, 1, 1, 7, 3, 1'b0, 1'b1, mkExp(1, MAX_FIRE, 1, -1, 3, 1, 0, 0, 1));
        observeBurst("cmp_timeout", MAX_FIRE + 100, 0, 0, 0, 1'b0);

        applyStimulus(2'b00, 3, 2, 2, 2, 1'b0, 1'b1, mkExp(6, 6, 3, 6, 2, 3, 0, 0, 0));
        observeBurst("fixed_three", 100, 0, 0, 0, 1'b0);

        applyStimulus(2'b00, 3, 2, 4, 2, 1'b0, 1'b1, mkExp(4, 6, 2, 8, 0, 1, 0, 1, 0));
        observeBurst("abort_shot2", 100, 0, 2, 2, 1'b1);

        applyStimulus(2'b01, 1, 2, 9, 2, 1'b0, 1'b1, mkExp(2, 7, 1, -1, 2, 1, 1, 0, 0));
        observeBurst("cmp_hit5", 100, 5, 0, 0, 1'b0);

        applyStimulus(2'b10, 1, 1, 12, 1, 1'b0, 1'b1, mkExp(1, 12, 1, -1, 1, 1, 1, 0, 0));
        observeBurst("edge_at_expiry", 100, 10, 0, 0, 1'b0);

        comparator = 1'b1;
        repeat (4) @(negedge avms_clk);
        applyStimulus(2'b10, 1, 1, 6, 1, 1'b0, 1'b1, mkExp(1, 6, 1, -1, 1, 1, 0, 0, 0));
        observeBurst("cmp_prehigh", 100, 0, 0, 0, 1'b0);

        applyStimulus(2'b00, 0, 0, 0, 0, 1'b0, 1'b1, mkExp(1, 1, 1, -1, 1, 1, 0, 0, 0));
        observeBurst("zero_lengths", 50, 0, 0, 0, 1'b0);

        applyStimulus(2'b11, 1, 2, 2, 2, 1'b0, 1'b0, none);
        idleActivity(6, act);
        checkOutput("cfg_err activity", act, 0);
        checkOutput("cfg_err flag", int'(regs.cfg_err), 1);

        applyStimulus(2'b00, 2, 1, 1, 1, 1'b0, 1'b1, mkExp(2, 2, 2, 3, 1, 2, 0, 0, 0));
        observeBurst("after_cfg_err", 50, 0, 0, 0, 1'b0);

        applyStimulus(2'b00, 1, 2, 2, 2, 1'b1, 1'b0, none);
        idleActivity(6, act);
        checkOutput("start_abort activity", act, 0);

        applyStimulus(2'b00, 1, 10, 5, 2, 1'b0, 1'b0, none);
        @(negedge avms_clk);
        checkOutput("pre_reset laser_charge", int'(laser_charge), 1);
        #2 avms_reset = 1'b1;
        #1;
        checkOutput("async_reset laser_charge", int'(laser_charge), 0);
        checkOutput("async_reset busy", int'(regs.busy), 0);
        checkOutput("async_reset laser_en", int'(laser_en), 0);
        @(negedge avms_clk);
        avms_reset = 1'b0;
        idleActivity(4, act);
        checkOutput("post_reset activity", act, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
